bram_req_adapter: RTL and testbench
===================================

BRAM_REQ_ADAPTER -- requirements
Module: bram_req_adapter

Interface
REQ-001 Parameters SHALL be as follows:
- ADDR_WIDTH, default 1: RAM address width.
- DATA_WIDTH, default 1: RAM data width.
- RESP_DEPTH, default 4: response buffer entries; power of two, at least 2.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- CLK  in  1  clock; the block has one clock.
- RST_N  in  1  reset; asynchronous, active-low.
- REQ_VALID  in  1  request offered.
- REQ_READY  out  1  request accepted when high together with REQ_VALID.
- REQ_WE  in  1  1 = write, 0 = read.
- REQ_ADDR  in  ADDR_WIDTH  request address.
- REQ_DATA  in  DATA_WIDTH  write data.
- RESP_VALID  out  1  read response available.
- RESP_READY  in  1  consumer takes the response.
- RESP_DATA  out  DATA_WIDTH  read data.
- RAM_ADDR  out  ADDR_WIDTH  to the block RAM port address.
- RAM_DI  out  DATA_WIDTH  to the block RAM port data in.
- RAM_WE  out  1  to the block RAM port write enable.
- RAM_RE  out  1  to the block RAM port read enable.
- RAM_DO  in  DATA_WIDTH  from the block RAM port; registered, valid one cycle after RAM_RE.

Function
REQ-003 A request SHALL be accepted ("fire") in a cycle where REQ_VALID and REQ_READY are both high.
REQ-004 RAM_ADDR SHALL equal REQ_ADDR and RAM_DI SHALL equal REQ_DATA combinationally.
REQ-005 RAM_WE SHALL equal fire AND REQ_WE.
REQ-006 RAM_RE SHALL equal fire AND NOT REQ_WE.
REQ-007 An in-flight flag SHALL be set on the cycle after a read fires and clear otherwise.
REQ-008 When the in-flight flag is set, RAM_DO SHALL be written into the response FIFO on that edge.
REQ-009 The number of used credits SHALL equal FIFO occupancy plus the in-flight flag.
- REQ_READY SHALL be high iff used credits < RESP_DEPTH.
- REQ_READY SHALL be independent of REQ_WE, REQ_VALID and RESP_READY; there is no combinational path from these inputs to REQ_READY.
REQ-010 Writes SHALL consume no credit beyond the REQ_READY condition and SHALL produce no response.
REQ-011 RESP_VALID SHALL be high iff the FIFO is non-empty. RESP_DATA SHALL be the FIFO head.
- A response pops when RESP_VALID and RESP_READY are both high.
REQ-012 Read-to-RESP_VALID latency SHALL be exactly 2 cycles when the FIFO is empty; there is no bypass path.
REQ-013 Responses SHALL be returned in request order.
REQ-014 While RESP_VALID is high and RESP_READY is low, RESP_DATA SHALL hold stable.
REQ-015 A simultaneous push and pop SHALL leave occupancy unchanged. This includes the case where the FIFO is full.
REQ-016 FIFO read and write pointers SHALL wrap modulo RESP_DEPTH.
- The occupancy counter SHALL be clog2(RESP_DEPTH)+1 bits wide.
REQ-017 With RESP_DEPTH at least 4 and RESP_READY held high, the block SHALL sustain one read per cycle.
REQ-018 A push into a full FIFO SHALL be impossible by construction (REQ-009).

Reset
REQ-019 While RST_N is low, the following SHALL apply asynchronously:
- The in-flight flag SHALL be cleared.
- FIFO pointers and occupancy SHALL be cleared.
- RESP_VALID, REQ_READY, RAM_WE and RAM_RE SHALL be 0.
- RESP_DATA SHALL be 0.
REQ-020 A reset asserted mid-operation SHALL discard all buffered and in-flight responses.
- REQ_READY SHALL rise in the first cycle after RST_N deasserts.
REQ-021 Stored FIFO data SHALL be reset-free, except that the RESP_DATA output SHALL read 0 while empty after reset.

Configuration
REQ-022 The macro BRAM_REQ_ADAPTER_STATS_EN SHALL control optional statistics.
- When defined, the block SHALL add output STAT_READS [31:0] and output STAT_WRITES [31:0].
- These SHALL count fired reads and fired writes respectively.
- Both SHALL reset to 0 and wrap from 0xFFFFFFFF to 0.
- When undefined, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-023 Single read, with RAM model holding 0x5A at address 3 and DATA_WIDTH 8:
- Stimulus: read of address 3 fires at cycle 0, RESP_READY held high.
- Response: RAM_RE is 1 at cycle 0 only, RESP_VALID is 1 at cycle 2, RESP_DATA = 0x5A.
REQ-024 Write then read, DATA_WIDTH 8:
- Stimulus: write 0xC3 to address 7, then read address 7 on the next cycle.
- Response: RAM_WE is 1 for exactly one cycle, one response of 0xC3, no response for the write.
REQ-025 Backpressure with RESP_DEPTH 4 and RESP_READY low:
- Stimulus: 6 back-to-back reads offered.
- Response: exactly 4 fire and REQ_READY drops; after RESP_READY rises, all 4 responses emerge in order with stable data during stall.
REQ-026 Streaming with RESP_DEPTH 4:
- Stimulus: 100 reads of addresses 0..99, RESP_READY high.
- Response: 100 ordered responses, with RESP_VALID continuously high from cycle 2 to cycle 101.
REQ-027 Reset mid-operation:
- Stimulus: RST_N pulsed low with 3 responses buffered and 1 read in flight.
- Response: RESP_VALID falls immediately; no stale response appears afterwards.
REQ-028 Statistics counters, with BRAM_REQ_ADAPTER_STATS_EN defined:
- Stimulus: 5 reads and 2 writes.
- Response: STAT_READS = 5 and STAT_WRITES = 2.

Source files
------------

// File: rtl/bram_req_adapter.sv
// bram_req_adapter
//   Turns a valid/ready request stream (reads and writes) into single-port
//   block RAM strobes and returns read data through a small response FIFO.
//   The RAM read port is registered (data one cycle after RAM_RE), so a read
//   takes one cycle "in flight" before it lands in the FIFO. Requests are
//   only accepted while a FIFO slot is guaranteed for every outstanding read,
//   so the FIFO can never overflow and REQ_READY depends only on state.
//
// Ports
//   CLK, RST_N                 clock, asynchronous active-low reset
//   REQ_VALID/REQ_READY        request handshake
//   REQ_WE, REQ_ADDR, REQ_DATA request: 1 = write, address, write data
//   RESP_VALID/RESP_READY      read-response handshake
//   RESP_DATA                  read data (FIFO head, 0 while empty)
//   RAM_ADDR, RAM_DI           RAM address / write data (pass-through)
//   RAM_WE, RAM_RE             RAM write / read strobes
//   RAM_DO                     RAM read data, valid one cycle after RAM_RE
//   STAT_READS, STAT_WRITES    fired read / write counters, present only
//                              when BRAM_REQ_ADAPTER_STATS_EN is defined
//
// Configuration macro: BRAM_REQ_ADAPTER_STATS_EN

module bram_req_adapter #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1,
  parameter int RESP_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WE,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ_DATA,
  output logic                  RESP_VALID,
  input  logic                  RESP_READY,
  output logic [DATA_WIDTH-1:0] RESP_DATA,
  output logic [ADDR_WIDTH-1:0] RAM_ADDR,
  output logic [DATA_WIDTH-1:0] RAM_DI,
  output logic                  RAM_WE,
  output logic                  RAM_RE,
  input  logic [DATA_WIDTH-1:0] RAM_DO
`ifdef BRAM_REQ_ADAPTER_STATS_EN
  ,
  output logic [31:0]           STAT_READS,
  output logic [31:0]           STAT_WRITES
`endif
);

  localparam int PW = $clog2(RESP_DEPTH);
  localparam int CW = PW + 1;
  localparam int UW = CW + 1;
  localparam logic [UW-1:0] DEPTH_C = UW'(RESP_DEPTH);

  logic [DATA_WIDTH-1:0] mem [RESP_DEPTH];
  logic [PW-1:0]         wptr, rptr;
  logic [CW-1:0]         count;
  logic                  inflight;
  logic                  fire, push, pop;
  logic [UW-1:0]         used;

  // Credits: every buffered response plus the read currently in the RAM.
  assign used      = {1'b0, count} + {{CW{1'b0}}, inflight};
  // Gating with RST_N holds ready low throughout reset and lets it rise
  // in the first cycle after release.
  assign REQ_READY = RST_N & (used < DEPTH_C);
  assign fire      = REQ_VALID & REQ_READY;

  assign RAM_ADDR  = REQ_ADDR;
  assign RAM_DI    = REQ_DATA;
  assign RAM_WE    = fire & REQ_WE;
  assign RAM_RE    = fire & ~REQ_WE;

  assign push       = inflight;
  assign RESP_VALID = (count != '0);
  assign pop        = RESP_VALID & RESP_READY;
  assign RESP_DATA  = RESP_VALID ? mem[rptr] : '0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      inflight <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
    end else begin
      inflight <= RAM_RE;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is reset-free; RESP_DATA is masked while empty instead.
  always_ff @(posedge CLK) begin
    if (push) mem[wptr] <= RAM_DO;
  end

`ifdef BRAM_REQ_ADAPTER_STATS_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      STAT_READS  <= '0;
      STAT_WRITES <= '0;
    end else begin
      if (RAM_RE) STAT_READS  <= STAT_READS + 32'd1;
      if (RAM_WE) STAT_WRITES <= STAT_WRITES + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bram_req_adapter.sv
// Testbench for bram_req_adapter (ADDR_WIDTH 8, DATA_WIDTH 8, RESP_DEPTH 4).
// A registered-read RAM model sits on the RAM port. Unwritten RAM locations
// read as (addr ^ 8'h59), so address 3 holds 8'h5A. The reference model is a
// queue of expected read data built from the request stream at each fire.

module tb_bram_req_adapter;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int DEPTH = 4;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          REQ_VALID = 1'b0;
  logic          REQ_WE = 1'b0;
  logic [AW-1:0] REQ_ADDR = '0;
  logic [DW-1:0] REQ_DATA = '0;
  logic          RESP_READY = 1'b0;
  logic          REQ_READY, RESP_VALID, RAM_WE, RAM_RE;
  logic [DW-1:0] RESP_DATA, RAM_DI, RAM_DO;
  logic [AW-1:0] RAM_ADDR;
`ifdef BRAM_REQ_ADAPTER_STATS_EN
  logic [31:0]   STAT_READS, STAT_WRITES;
`endif

  bram_req_adapter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
    .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
    .RESP_VALID(RESP_VALID), .RESP_READY(RESP_READY), .RESP_DATA(RESP_DATA),
    .RAM_ADDR(RAM_ADDR), .RAM_DI(RAM_DI), .RAM_WE(RAM_WE), .RAM_RE(RAM_RE),
    .RAM_DO(RAM_DO)
`ifdef BRAM_REQ_ADAPTER_STATS_EN
    , .STAT_READS(STAT_READS), .STAT_WRITES(STAT_WRITES)
`endif
  );

  always #5 CLK = ~CLK;

  // RAM model: registered read, write overlay over a fixed background pattern.
  logic [DW-1:0] ram_val [256];
  bit            ram_wr  [256];
  always @(posedge CLK) begin
    if (RAM_WE) begin
      ram_val[RAM_ADDR] <= RAM_DI;
      ram_wr[RAM_ADDR]  <= 1'b1;
    end
    if (RAM_RE) RAM_DO <= ram_wr[RAM_ADDR] ? ram_val[RAM_ADDR] : (RAM_ADDR ^ 8'h59);
  end

  // Reference model state.
  logic [DW-1:0] ref_val [256];
  bit            ref_wr  [256];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  bit            re_h[$], we_h[$], v_h[$];
  int            nrd, nwr, stall_bad;
  bit            prev_stall, last_fire;
  logic [DW-1:0] prev_data;
  int            passed, total;

  // Advance one cycle: sample the handshakes mid-cycle, update the model and
  // record pops; leaves time at the next falling edge.
  task automatic tick();
    bit f, p;
    #1;
    f = REQ_VALID && REQ_READY;
    p = RESP_VALID && RESP_READY;
    re_h.push_back(RAM_RE);
    we_h.push_back(RAM_WE);
    v_h.push_back(RESP_VALID);
    if (f) begin
      if (REQ_WE) begin
        ref_wr[REQ_ADDR]  = 1'b1;
        ref_val[REQ_ADDR] = REQ_DATA;
        nwr++;
      end else begin
        exp_q.push_back(ref_wr[REQ_ADDR] ? ref_val[REQ_ADDR] : (REQ_ADDR ^ 8'h59));
        nrd++;
      end
    end
    if (p) got_q.push_back(RESP_DATA);
    if (prev_stall && RESP_VALID && (RESP_DATA !== prev_data)) stall_bad++;
    prev_stall = RESP_VALID && !RESP_READY;
    prev_data  = RESP_DATA;
    last_fire  = f;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic clear_hist();
    exp_q.delete(); got_q.delete();
    re_h.delete(); we_h.delete(); v_h.delete();
  endtask

  task automatic test_reset();
    REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = 8'd3;
    #1;
    total++; if (REQ_READY !== 1'b0) $display("FAIL reset_ready got=%b exp=0", REQ_READY); else passed++;
    total++; if (RESP_VALID !== 1'b0) $display("FAIL reset_valid got=%b exp=0", RESP_VALID); else passed++;
    total++; if (RESP_DATA !== 8'h00) $display("FAIL reset_data got=%h exp=00", RESP_DATA); else passed++;
    total++; if (RAM_RE !== 1'b0) $display("FAIL reset_ram_re got=%b exp=0", RAM_RE); else passed++;
    REQ_WE = 1'b1;
    #1;
    total++; if (RAM_WE !== 1'b0) $display("FAIL reset_ram_we got=%b exp=0", RAM_WE); else passed++;
    REQ_VALID = 1'b0; REQ_WE = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    total++; if (REQ_READY !== 1'b1) $display("FAIL ready_after_reset got=%b exp=1", REQ_READY); else passed++;
    @(negedge CLK);
  endtask

  task automatic test_single_read();
    clear_hist();
    RESP_READY = 1'b1;
    REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = 8'd3;
    tick();
    REQ_VALID = 1'b0;
    repeat (4) tick();
    total++; if ({re_h[0], re_h[1], re_h[2]} !== 3'b100)
      $display("FAIL single_ram_re got=%b%b%b exp=100", re_h[0], re_h[1], re_h[2]); else passed++;
    total++; if ({v_h[1], v_h[2], v_h[3]} !== 3'b010)
      $display("FAIL single_latency got=%b%b%b exp=010", v_h[1], v_h[2], v_h[3]); else passed++;
    total++; if (got_q.size() !== 1) $display("FAIL single_count got=%0d exp=1", got_q.size()); else passed++;
    if (got_q.size() > 0) begin
      total++; if (got_q[0] !== 8'h5A) $display("FAIL single_data got=%h exp=5a", got_q[0]); else passed++;
    end
  endtask

  task automatic test_write_read();
    int wcnt;
    clear_hist();
    RESP_READY = 1'b1;
    REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = 8'd7; REQ_DATA = 8'hC3;
    tick();
    REQ_WE = 1'b0; REQ_DATA = 8'h00;
    tick();
    REQ_VALID = 1'b0;
    repeat (4) tick();
    wcnt = 0;
    foreach (we_h[i]) wcnt += int'(we_h[i]);
    total++; if (wcnt !== 1) $display("FAIL wr_we_cycles got=%0d exp=1", wcnt); else passed++;
    total++; if (got_q.size() !== 1) $display("FAIL wr_resp_count got=%0d exp=1", got_q.size()); else passed++;
    if (got_q.size() > 0) begin
      total++; if (got_q[0] !== 8'hC3) $display("FAIL wr_read_data got=%h exp=c3", got_q[0]); else passed++;
    end
  endtask

  task automatic test_backpressure();
    int idx, n0;
    clear_hist();
    stall_bad = 0;
    RESP_READY = 1'b0;
    n0 = nrd; idx = 0;
    for (int c = 0; c < 10 && idx < 6; c++) begin
      REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = AW'($urandom_range(0, 255));
      tick();
      if (last_fire) idx++;
    end
    #1;
    total++; if (nrd - n0 !== 4) $display("FAIL bp_fired got=%0d exp=4", nrd - n0); else passed++;
    total++; if (REQ_READY !== 1'b0) $display("FAIL bp_ready_low got=%b exp=0", REQ_READY); else passed++;
    @(negedge CLK);
    REQ_VALID = 1'b0;
    repeat (3) tick();
    RESP_READY = 1'b1;
    repeat (8) tick();
    total++; if (stall_bad !== 0) $display("FAIL bp_stall_stable got=%0d exp=0", stall_bad); else passed++;
    total++; if (got_q.size() !== exp_q.size()) $display("FAIL bp_resp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) $display("FAIL bp_order[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); else passed++;
    end
  endtask

  task automatic test_stream();
    int i, cyc, ones;
    clear_hist();
    RESP_READY = 1'b1;
    i = 0; cyc = 0;
    while (i < 100 && cyc < 200) begin
      REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = AW'(i);
      tick();
      cyc++;
      if (last_fire) i++;
    end
    REQ_VALID = 1'b0;
    repeat (4) tick();
    total++; if (cyc !== 100) $display("FAIL stream_cycles got=%0d exp=100", cyc); else passed++;
    ones = 0;
    for (int k = 2; k <= 101 && k < v_h.size(); k++) ones += int'(v_h[k]);
    total++; if (ones !== 100 || v_h[1] !== 1'b0)
      $display("FAIL stream_valid_run got=%0d v1=%b exp=100 v1=0", ones, v_h[1]); else passed++;
    total++; if (got_q.size() !== 100) $display("FAIL stream_count got=%0d exp=100", got_q.size()); else passed++;
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      total++; if (got_q[k] !== exp_q[k]) $display("FAIL stream_data[%0d] got=%h exp=%h", k, got_q[k], exp_q[k]); else passed++;
    end
  endtask

  task automatic test_random();
    clear_hist();
    stall_bad = 0;
    for (int c = 0; c < 400; c++) begin
      REQ_VALID  = ($urandom_range(0, 9) < 7);
      REQ_WE     = ($urandom_range(0, 9) < 3);
      REQ_ADDR   = AW'($urandom_range(0, 31));
      REQ_DATA   = DW'($urandom);
      RESP_READY = ($urandom_range(0, 9) < 6);
      tick();
    end
    REQ_VALID = 1'b0; RESP_READY = 1'b1;
    repeat (10) tick();
    total++; if (stall_bad !== 0) $display("FAIL rand_stall_stable got=%0d exp=0", stall_bad); else passed++;
    total++; if (got_q.size() !== exp_q.size()) $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else passed++;
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      total++; if (got_q[k] !== exp_q[k]) $display("FAIL rand_data[%0d] got=%h exp=%h", k, got_q[k], exp_q[k]); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    clear_hist();
    RESP_READY = 1'b0;
    repeat (4) begin
      REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = AW'($urandom_range(0, 255));
      tick();
    end
    REQ_VALID = 1'b0;
    #1;
    total++; if (RESP_VALID !== 1'b1) $display("FAIL mid_pre_valid got=%b exp=1", RESP_VALID); else passed++;
    RST_N = 1'b0;
    #1;
    total++; if (RESP_VALID !== 1'b0) $display("FAIL mid_valid_drop got=%b exp=0", RESP_VALID); else passed++;
    total++; if (REQ_READY !== 1'b0) $display("FAIL mid_ready_low got=%b exp=0", REQ_READY); else passed++;
    total++; if (RESP_DATA !== 8'h00) $display("FAIL mid_data_zero got=%h exp=00", RESP_DATA); else passed++;
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    clear_hist();
    nrd = 0; nwr = 0; prev_stall = 1'b0;
    RESP_READY = 1'b1;
    repeat (6) tick();
    total++; if (got_q.size() !== 0) $display("FAIL mid_stale_resp got=%0d exp=0", got_q.size()); else passed++;
  endtask

`ifdef BRAM_REQ_ADAPTER_STATS_EN
  task automatic test_stats();
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    nrd = 0; nwr = 0; clear_hist();
    RESP_READY = 1'b1;
    for (int k = 0; k < 7; k++) begin
      REQ_VALID = 1'b1; REQ_WE = (k == 1 || k == 4);
      REQ_ADDR = AW'(k); REQ_DATA = DW'(k);
      tick();
    end
    REQ_VALID = 1'b0;
    repeat (3) tick();
    total++; if (STAT_READS !== 32'd5) $display("FAIL stat_reads got=%0d exp=5", STAT_READS); else passed++;
    total++; if (STAT_WRITES !== 32'd2) $display("FAIL stat_writes got=%0d exp=2", STAT_WRITES); else passed++;
  endtask
`endif

  initial begin
    passed = 0; total = 0; nrd = 0; nwr = 0; stall_bad = 0;
    prev_stall = 1'b0; prev_data = '0; last_fire = 1'b0;
    test_reset();
    test_single_read();
    test_write_read();
    test_backpressure();
    test_stream();
    test_random();
    test_reset_mid();
`ifdef BRAM_REQ_ADAPTER_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
